conv_seq_ctrl: RTL
==================

Name: conv_seq_ctrl

Overview:
- Hardware instruction sequencer for the core: produces, on its own, the phase sequence the bench drives by hand today.
- Phases per kij: kernel load, kernel gap, activation load, execute gap, OFIFO drain into pmem. A final accumulation pass then reads pmem per output pixel.
- Parametrised in array size, kernel size, input width and gap lengths.
- Sits between the top-level start/status interface and the core's inst/xmem/pmem control inputs.

Parameters:
- ROW, 8, PE rows (activation channels per xmem word)
- COL, 8, PE columns (weight words per kij)
- KSZ, 3, kernel side; LEN_KIJ = KSZ*KSZ
- IN_W, 6, input feature map side; LEN_NIJ = IN_W*IN_W
- OUT_W, 4, output side = IN_W-KSZ+1; LEN_ONIJ = OUT_W*OUT_W
- XA_W, 11, xmem address width
- PA_W, 11, pmem address width
- WBASE, 1024, xmem base address of weights
- KGAP, 10, idle cycles after kernel load
- XGAP, 30, idle cycles after activation load

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low; reset=0 on a rising edge initialises the block
- start  in  1  one-cycle pulse that begins a run
- ofifo_valid  in  1  OFIFO holds at least one psum row
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- inst_w  out  2  01 kernel load, 10 activation load/execute, 00 idle
- CEN_xmem, WEN_xmem  out  1 each  xmem enables, active-low
- A_xmem  out  XA_W  xmem address
- ofifo_rd  out  1  OFIFO pop
- CEN_pmem, WEN_pmem  out  1 each  pmem enables, active-low
- A_pmem  out  PA_W  pmem address
- acc  out  1  SFP accumulate enable
- acc_clr  out  1  SFP accumulator clear pulse
- sfp_valid  out  1  sfp_out holds a finished output pixel
- kij  out  4  current kernel index

Behaviour:
- Outputs:
  - All outputs are registered.
  - Reset values: busy=0, done=0, inst_w=00, CEN_xmem=WEN_xmem=CEN_pmem=WEN_pmem=1, all addresses 0, ofifo_rd=acc=acc_clr=sfp_valid=0, kij=0.
  - Reset asserted mid-run returns to IDLE next edge with the reset values above; no partial phase completes.
- States: IDLE, KLOAD, KGAP, ALOAD, XGAP, DRAIN, ACC, FIN.
- IDLE:
  - start=1 → KLOAD with kij=0 and busy=1.
  - start while busy is ignored.
- KLOAD (COL cycles, t=0..COL-1): CEN_xmem=0, WEN_xmem=1, A_xmem=WBASE+kij*COL+t, inst_w=01.
- KGAP (KGAP cycles): inst_w=00, CEN_xmem=1.
- ALOAD (LEN_NIJ cycles, t=0..LEN_NIJ-1): CEN_xmem=0, WEN_xmem=1, A_xmem=t, inst_w=10.
- XGAP: XGAP cycles idle.
- DRAIN:
  - Counter d runs 0..LEN_NIJ-1.
  - Each cycle with ofifo_valid=1 and d<LEN_NIJ: ofifo_rd=1.
  - Exactly one cycle later: CEN_pmem=0, WEN_pmem=0, A_pmem=kij*LEN_NIJ+d (the popped row lands next cycle); d increments.
  - ofifo_valid=0 inserts a bubble; ofifo_rd is never asserted with ofifo_valid=0.
  - After the last write: if kij<LEN_KIJ-1, kij++ → KLOAD; else → ACC.
- ACC, per output pixel o=0..LEN_ONIJ-1, with orow=o/OUT_W, ocol=o%OUT_W:
  - Cycle 0: acc_clr=1.
  - Cycles 1..LEN_KIJ: read j=0..LEN_KIJ-1 with CEN_pmem=0, WEN_pmem=1, A_pmem=j*LEN_NIJ+(orow+j/KSZ)*IN_W+(ocol+j%KSZ).
  - acc=1 on cycles 2..LEN_KIJ+1, one cycle behind each read; cycle LEN_KIJ+1 has CEN_pmem=1.
  - Cycle LEN_KIJ+2: acc=0, sfp_valid=1.
  - Each pixel therefore takes LEN_KIJ+3 cycles.
- FIN: done=1 for one cycle, busy=0 → IDLE.
- Arithmetic: address arithmetic is unsigned and truncated to XA_W/PA_W. Elaboration errors if LEN_KIJ*LEN_NIJ > 2^PA_W, or if WBASE+LEN_KIJ*COL > 2^XA_W.
- Phase boundaries add no dead cycles beyond those stated.

Decomposition:
- Package conv_seq_pkg holds:
  - state enum;
  - inst_w encodings (INST_IDLE=00, INST_KLOAD=01, INST_XLOAD=10);
  - derived localparams LEN_KIJ, LEN_NIJ, LEN_ONIJ.
- One sub-module, conv_acc_addr_gen: given o and j, produces the ACC-phase pmem address. It is combinational plus registered orow/ocol counters, so no divide is needed in hardware.

Test Plan:
- Reset then start, ofifo_valid tied 1 → first KLOAD cycle A_xmem=1024, inst_w=01; 8 cycles to 1031; KGAP 10 idle cycles; ALOAD A_xmem 0..35, inst_w=10.
- kij=4 in KLOAD → A_xmem=1056..1063; DRAIN writes A_pmem=144..179, each write one cycle after its ofifo_rd.
- ofifo_valid toggled 1,0,1 during DRAIN → ofifo_rd=1,0,1; pmem writes at d=0,1 with one bubble; 36 writes total.
- ACC o=0 → acc_clr pulse, then A_pmem = 0,37,74,114,151,188,228,265,302; acc high 9 cycles; sfp_valid at cycle 11. o=5 (orow=1, ocol=1) first address 7.
- Full run → done pulses exactly once; total sfp_valid pulses = 16; busy low afterwards.
- reset=0 asserted during ALOAD of kij=2 → next edge all outputs at reset values, state IDLE; a new start restarts at kij=0.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared state enum, inst_w encodings and default sizes
// for the conv sequencer and its accumulation address generator.
package conv_seq_pkg;

   localparam int ROW_D   = 8;
   localparam int COL_D   = 8;
   localparam int KSZ_D   = 3;
   localparam int IN_W_D  = 6;
   localparam int OUT_W_D = IN_W_D - KSZ_D + 1;

   localparam int LEN_KIJ  = KSZ_D * KSZ_D;
   localparam int LEN_NIJ  = IN_W_D * IN_W_D;
   localparam int LEN_ONIJ = OUT_W_D * OUT_W_D;

   // internal counter width, ample for every phase length
   localparam int CW = 16;

   localparam logic [1:0] INST_IDLE  = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_XLOAD = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KLOAD,
      S_KGAP,
      S_ALOAD,
      S_XGAP,
      S_DRAIN,
      S_ACC,
      S_FIN
   } state_e;

endpackage

// File: rtl/conv_acc_addr_gen.sv
// conv_acc_addr_gen: pmem read address for output pixel o, kernel tap j.
// Ports: clr zeroes orow/ocol, step advances to the next pixel, j = tap,
//   addr = j*LEN_NIJ + (orow+j/KSZ)*IN_W + ocol + j%KSZ.
module conv_acc_addr_gen
   import conv_seq_pkg::*;
#(
   parameter int KSZ   = KSZ_D,
   parameter int IN_W  = IN_W_D,
   parameter int OUT_W = OUT_W_D,
   parameter int PA_W  = 11
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            step,
   input  logic [CW-1:0]   j,
   output logic [PA_W-1:0] addr
);

   localparam logic [CW-1:0] K_C   = CW'(KSZ);
   localparam logic [CW-1:0] OC_LS = CW'(OUT_W - 1);

   logic [CW-1:0] orow_q, orow_d;
   logic [CW-1:0] ocol_q, ocol_d;
   logic [CW-1:0] krow, kcol;

   // pixel row/col tracked as counters instead of dividing o
   always_comb begin
      orow_d = orow_q;
      ocol_d = ocol_q;
      if (clr) begin
         orow_d = '0;
         ocol_d = '0;
      end else if (step) begin
         if (ocol_q == OC_LS) begin
            ocol_d = '0;
            orow_d = orow_q + 1'b1;
         end else begin
            ocol_d = ocol_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         orow_q <= '0;
         ocol_q <= '0;
      end else begin
         orow_q <= orow_d;
         ocol_q <= ocol_d;
      end
   end

   // j is tiny and KSZ constant, so this folds to a small table
   always_comb begin
      krow = j / K_C;
      kcol = j % K_C;
      addr = PA_W'(j) * PA_W'(IN_W * IN_W)
           + PA_W'(orow_q + krow) * PA_W'(IN_W)
           + PA_W'(ocol_q + kcol);
   end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: per-kij kernel load, activation load, OFIFO drain into
// pmem, then one accumulation pass per output pixel. All outputs registered.
// Ports: clk, reset (sync, active-low), start/busy/done, inst_w,
//   xmem CEN/WEN/A, ofifo_valid/ofifo_rd, pmem CEN/WEN/A, SFP acc/acc_clr/
//   sfp_valid, kij.
module conv_seq_ctrl
   import conv_seq_pkg::*;
#(
   parameter int ROW   = ROW_D,
   parameter int COL   = COL_D,
   parameter int KSZ   = KSZ_D,
   parameter int IN_W  = IN_W_D,
   parameter int OUT_W = OUT_W_D,
   parameter int XA_W  = 11,
   parameter int PA_W  = 11,
   parameter int WBASE = 1024,
   parameter int KGAP  = 10,
   parameter int XGAP  = 30
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            ofifo_valid,
   output logic            busy,
   output logic            done,
   output logic [1:0]      inst_w,
   output logic            CEN_xmem,
   output logic            WEN_xmem,
   output logic [XA_W-1:0] A_xmem,
   output logic            ofifo_rd,
   output logic            CEN_pmem,
   output logic            WEN_pmem,
   output logic [PA_W-1:0] A_pmem,
   output logic            acc,
   output logic            acc_clr,
   output logic            sfp_valid,
   output logic [3:0]      kij
);

   localparam int N_KIJ  = KSZ * KSZ;
   localparam int N_NIJ  = IN_W * IN_W;
   localparam int N_ONIJ = OUT_W * OUT_W;

   localparam logic [CW-1:0] C_KLD  = CW'(COL - 1);
   localparam logic [CW-1:0] C_KGP  = CW'(KGAP - 1);
   localparam logic [CW-1:0] C_ALD  = CW'(N_NIJ - 1);
   localparam logic [CW-1:0] C_XGP  = CW'(XGAP - 1);
   localparam logic [CW-1:0] C_NIJ  = CW'(N_NIJ);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_RDE  = CW'(N_KIJ);
   localparam logic [CW-1:0] C_PIX  = CW'(N_KIJ + 2);
   localparam logic [CW-1:0] C_ONIJ = CW'(N_ONIJ - 1);
   localparam logic [3:0]    K_LAST = 4'(N_KIJ - 1);

   if (N_KIJ * N_NIJ > (32'(1) << PA_W)) begin : g_pa_chk
      $error("pmem address space too small for all psums");
   end
   if (WBASE + N_KIJ * COL > (32'(1) << XA_W)) begin : g_xa_chk
      $error("xmem address space too small for weights");
   end
   if (OUT_W != IN_W - KSZ + 1) begin : g_ow_chk
      $error("OUT_W must equal IN_W-KSZ+1");
   end
   if (N_KIJ > 16 || ROW < 1) begin : g_sz_chk
      $error("kernel too large for kij port or ROW invalid");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   wr_q, wr_d;
   logic [CW-1:0]   o_q, o_d;
   logic [3:0]      kij_q, kij_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [1:0]      inst_q, inst_d;
   logic            cen_x_q, cen_x_d;
   logic            wen_x_q, wen_x_d;
   logic [XA_W-1:0] a_x_q, a_x_d;
   logic            rd_q, rd_d;
   logic            cen_p_q, cen_p_d;
   logic            wen_p_q, wen_p_d;
   logic [PA_W-1:0] a_p_q, a_p_d;
   logic            acc_q, acc_d;
   logic            clr_q, clr_d;
   logic            sfpv_q, sfpv_d;
   logic [PA_W-1:0] acc_addr;

   // orow/ocol held at 0 until ACC; they advance after each pixel's
   // last cycle so they are valid again by that pixel's first read
   conv_acc_addr_gen #(
      .KSZ   (KSZ),
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .PA_W  (PA_W)
   ) u_addr (
      .clk   (clk),
      .reset (reset),
      .clr   (state_q != S_ACC),
      .step  ((state_q == S_ACC) && (cnt_q == C_PIX)),
      .j     (cnt_q),
      .addr  (acc_addr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      o_d     = o_q;
      kij_d   = kij_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_KLOAD;
               cnt_d   = '0;
               kij_d   = '0;
            end
         end
         S_KLOAD: begin
            if (cnt_q == C_KLD) begin
               state_d = S_KGAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_KGAP: begin
            if (cnt_q == C_KGP) begin
               state_d = S_ALOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ALOAD: begin
            if (cnt_q == C_ALD) begin
               state_d = S_XGAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_XGAP: begin
            if (cnt_q == C_XGP) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
               wr_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // wr_q reaching N_NIJ means the last write is on the bus now
            if (wr_q == C_NIJ) begin
               cnt_d = '0;
               if (kij_q == K_LAST) begin
                  state_d = S_ACC;
                  o_d     = '0;
               end else begin
                  state_d = S_KLOAD;
                  kij_d   = kij_q + 1'b1;
               end
            end
         end
         S_ACC: begin
            if (cnt_q == C_PIX) begin
               cnt_d = '0;
               if (o_q == C_ONIJ) begin
                  state_d = S_FIN;
               end else begin
                  o_d = o_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // registered outputs describe the cycle that state_d/cnt_d name
      busy_d  = (state_d != S_IDLE) && (state_d != S_FIN);
      done_d  = (state_d == S_FIN);
      inst_d  = INST_IDLE;
      cen_x_d = 1'b1;
      wen_x_d = 1'b1;
      a_x_d   = a_x_q;
      rd_d    = 1'b0;
      cen_p_d = 1'b1;
      wen_p_d = 1'b1;
      a_p_d   = a_p_q;
      acc_d   = 1'b0;
      clr_d   = 1'b0;
      sfpv_d  = 1'b0;
      unique case (state_d)
         S_KLOAD: begin
            inst_d  = INST_KLOAD;
            cen_x_d = 1'b0;
            a_x_d   = XA_W'(WBASE)
                    + XA_W'(kij_d) * XA_W'(COL)
                    + XA_W'(cnt_d);
         end
         S_ALOAD: begin
            inst_d  = INST_XLOAD;
            cen_x_d = 1'b0;
            a_x_d   = XA_W'(cnt_d);
         end
         S_DRAIN: begin
            // in DRAIN cnt counts pops issued
            rd_d = ofifo_valid && (cnt_d < C_NIJ);
            if (rd_d) begin
               cnt_d = cnt_d + 1'b1;
            end
            if (rd_q) begin
               cen_p_d = 1'b0;
               wen_p_d = 1'b0;
               a_p_d   = PA_W'(kij_d) * PA_W'(N_NIJ)
                       + PA_W'(wr_q);
               wr_d    = wr_q + 1'b1;
            end
         end
         S_ACC: begin
            clr_d  = (cnt_d == '0);
            acc_d  = (cnt_d > C_ONE) && (cnt_d < C_PIX);
            sfpv_d = (cnt_d == C_PIX);
            if ((cnt_d != '0) && (cnt_d <= C_RDE)) begin
               cen_p_d = 1'b0;
               a_p_d   = acc_addr;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= '0;
         o_q     <= '0;
         kij_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         inst_q  <= INST_IDLE;
         cen_x_q <= 1'b1;
         wen_x_q <= 1'b1;
         a_x_q   <= '0;
         rd_q    <= 1'b0;
         cen_p_q <= 1'b1;
         wen_p_q <= 1'b1;
         a_p_q   <= '0;
         acc_q   <= 1'b0;
         clr_q   <= 1'b0;
         sfpv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         o_q     <= o_d;
         kij_q   <= kij_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         inst_q  <= inst_d;
         cen_x_q <= cen_x_d;
         wen_x_q <= wen_x_d;
         a_x_q   <= a_x_d;
         rd_q    <= rd_d;
         cen_p_q <= cen_p_d;
         wen_p_q <= wen_p_d;
         a_p_q   <= a_p_d;
         acc_q   <= acc_d;
         clr_q   <= clr_d;
         sfpv_q  <= sfpv_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign inst_w    = inst_q;
   assign CEN_xmem  = cen_x_q;
   assign WEN_xmem  = wen_x_q;
   assign A_xmem    = a_x_q;
   assign ofifo_rd  = rd_q;
   assign CEN_pmem  = cen_p_q;
   assign WEN_pmem  = wen_p_q;
   assign A_pmem    = a_p_q;
   assign acc       = acc_q;
   assign acc_clr   = clr_q;
   assign sfp_valid = sfpv_q;
   assign kij       = kij_q;

endmodule
